// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the MEM-stage data-memory interface.
// One request is outstanding at a time. The access happens LATENCY edges after
// the accept edge, or on the accept edge itself when LATENCY is 1. The result is
// returned as a one-cycle resp_valid pulse, and the hazard unit stalls on busy.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         DEPTH            = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT         = 4'(LATENCY - 1);
  localparam bit         ACCESS_ON_ACCEPT = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_wait_done;
  logic                    w_access;
  logic                    w_acc_write;
  logic [31:0]             w_acc_addr;
  logic [31:0]             w_acc_wdata;
  logic [3:0]              w_acc_be;
  logic                    w_acc_err;
  logic [ADDR_WIDTH-1:0]   w_acc_idx;

  // A request is bad when it is not word aligned or its word index lies beyond the array.
  function automatic logic addr_is_bad(input logic [31:0] addr);
    logic [29:0] word;
    word = addr[31:2];
    return (addr[1:0] != 2'd0) || ((word >> ADDR_WIDTH) != 30'd0);
  endfunction

  // Handshake and stall outputs depend on the state register only.
  assign req_ready   = (r_state != ST_WAIT);
  assign busy        = (r_state == ST_WAIT);
  assign w_accept    = req_valid && req_ready;
  assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_access    = w_wait_done || (ACCESS_ON_ACCEPT && w_accept);
  assign w_acc_idx   = w_acc_addr[ADDR_WIDTH+1:2];
  assign w_acc_err   = addr_is_bad(w_acc_addr);

  // Access operands: latched request while waiting, live request when accessing on accept.
  always_comb begin
    w_acc_write = req_write;
    w_acc_addr  = req_addr;
    w_acc_wdata = req_wdata;
    w_acc_be    = req_be;
    if (r_state == ST_WAIT) begin
      w_acc_write = r_write;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
    end else begin
      w_acc_write = req_write;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
      w_acc_be    = req_be;
    end
  end

  // Next-state logic for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ACCESS_ON_ACCEPT ? ST_RESP : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          w_state_nxt = ACCESS_ON_ACCEPT ? ST_RESP : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch on accept and the latency down-counter while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered response; data and error hold until the next access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= w_access;
      if (w_access) begin
        if (w_acc_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end else if (w_acc_write) begin
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end else begin
          resp_err   <= 1'b0;
          resp_rdata <= r_mem[w_acc_idx];
        end
      end
    end
  end

  // Array write port: byte-lane store at the access edge, suppressed for bad addresses.
  always_ff @(posedge clk) begin
    if (w_access && w_acc_write && !w_acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
